// File: rtl/rv_core_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset core.
// Holds the opcode/funct3 encodings, the control FSM state type, the ALU
// operation type and the helper that maps funct3 (+ funct7[5]) onto an ALU op.
package rv_core_pkg;

  localparam logic [6:0] OPCODE_R = 7'b0110011;
  localparam logic [6:0] OPCODE_I = 7'b0010011;
  localparam logic [6:0] OPCODE_B = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB} state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  // alt is instr[30]; callers pass 0 when it must not select SUB (OP-IMM addi).
  function automatic alu_op_t f3_to_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv_multicycle_core_if.sv
// Instruction-memory fetch bus.
//  req   master->slave  fetch request, held until ack
//  addr  master->slave  byte address, stable while req
//  ack   slave->master  rdata valid this cycle
//  rdata slave->master  instruction word
interface rv_multicycle_core_if #(
  parameter int XLEN = 32
) ();
  logic            req;
  logic [XLEN-1:0] addr;
  logic            ack;
  logic [31:0]     rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/core_alu.sv
// Combinational ALU for the multi-cycle core.
//  op      ALU operation
//  a, b    operands (shift amount is b[4:0])
//  result  operation result, mod 2^XLEN
//  zero    result == 0 (a == b when op is SUB)
//  lt/ltu  signed / unsigned a < b
module core_alu
  import rv_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            lt,
  output logic            ltu
);
  logic [4:0] shamt;

  assign shamt = b[4:0];
  assign lt    = $signed(a) < $signed(b);
  assign ltu   = a < b;
  assign zero  = (result == '0);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, ltu};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $signed(a) >>> shamt;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end
endmodule

// File: rtl/rv_multicycle_core.sv
// Multi-cycle RV32I-subset core (OP, OP-IMM, BRANCH). Each instruction walks
// IDLE -> FETCH -> DECODE -> EXEC -> WB. Starts on run (free-running) or a
// step_en pulse; an unknown opcode sets the sticky halted flag.
//  sys_clk/sys_rst  clock, synchronous active-high reset
//  step_en/run      start controls, sampled only in IDLE
//  imem             fetch bus master (req/addr out, ack/rdata in)
//  dbg_pc           current pc
//  dbg_src_a/b      low byte of the operands of the last executed instruction
//  dbg_result       low byte of the ALU result of the last executed instruction
//  retired          1-cycle pulse in WB
//  halted           sticky illegal-opcode flag, cleared only by reset
module rv_multicycle_core
  import rv_core_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              MEM_BYTES = 64,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              NREGS     = 32
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 step_en,
  input  logic                 run,
  rv_multicycle_core_if.master imem,
  output logic [XLEN-1:0]      dbg_pc,
  output logic [7:0]           dbg_src_a,
  output logic [7:0]           dbg_src_b,
  output logic [7:0]           dbg_result,
  output logic                 retired,
  output logic                 halted
);
  localparam logic [XLEN-1:0] MEMB = XLEN'(MEM_BYTES);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ir_q;
  logic            halted_q;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] opa_q, opb_q, imm_q, res_q;
  alu_op_t         alu_op_q;
  logic            taken_q;
  logic [7:0]      dbg_a_q, dbg_b_q, dbg_r_q;

  // Instruction fields
  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      f3;
  logic [XLEN-1:0] rs1_val, rs2_val, imm_i, imm_b;
  logic            legal;
  alu_op_t         dec_op;

  assign opcode  = ir_q[6:0];
  assign rd      = ir_q[11:7];
  assign f3      = ir_q[14:12];
  assign rs1     = ir_q[19:15];
  assign rs2     = ir_q[24:20];
  assign rs1_val = (rs1 == 5'd0) ? '0 : regs_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs_q[rs2];
  assign imm_i   = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
  assign imm_b   = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};

  always_comb begin
    legal  = 1'b0;
    dec_op = ALU_ADD;
    case (opcode)
      OPCODE_R: begin
        legal  = 1'b1;
        dec_op = f3_to_alu(f3, ir_q[30]);
      end
      OPCODE_I: begin
        legal  = 1'b1;
        // Only the shift-right encoding uses instr[30]; addi never becomes SUB.
        dec_op = f3_to_alu(f3, (f3 == F3_SR) && ir_q[30]);
      end
      OPCODE_B: begin
        legal  = (f3 == F3_BEQ) || (f3 == F3_BNE) || (f3 == F3_BLT) || (f3 == F3_BGE);
        dec_op = ALU_SUB;
      end
      default: ;
    endcase
  end

  logic [XLEN-1:0] alu_res;
  logic            alu_zero, alu_lt, alu_ltu, cmp_lt, taken_c;

  core_alu #(.XLEN(XLEN)) u_alu (
    .op     (alu_op_q),
    .a      (opa_q),
    .b      (opb_q),
    .result (alu_res),
    .zero   (alu_zero),
    .lt     (alu_lt),
    .ltu    (alu_ltu)
  );

  // funct3[1] picks the unsigned compare (bltu/bgeu encodings); decode
  // currently rejects those, so only the signed path is reachable.
  // funct3[2] selects compare vs equality, funct3[0] inverts the sense.
  always_comb begin
    cmp_lt  = f3[1] ? alu_ltu : alu_lt;
    taken_c = 1'b0;
    if (opcode == OPCODE_B) begin
      taken_c = (f3[2] ? cmp_lt : alu_zero) ^ f3[0];
    end
  end

  // Sequential overflow restarts at RESET_PC; branch targets (possibly
  // negative) are folded into the instruction space modulo its size.
  logic [XLEN-1:0] seq_pc, tgt_pc;
  assign seq_pc = pc_q + XLEN'(4);
  assign tgt_pc = pc_q + imm_q;

  always_comb begin
    if (taken_q)            pc_d = tgt_pc % MEMB;
    else if (seq_pc >= MEMB) pc_d = RESET_PC;
    else                    pc_d = seq_pc;
    pc_d[1:0] = 2'b00;
  end

  always_comb begin
    state_d  = state_q;
    imem.req = 1'b0;
    retired  = 1'b0;
    case (state_q)
      IDLE:   if ((run || step_en) && !halted_q) state_d = FETCH;
      FETCH: begin
        imem.req = 1'b1;
        if (imem.ack) state_d = DECODE;
      end
      DECODE: state_d = legal ? EXEC : IDLE;
      EXEC:   state_d = WB;
      WB: begin
        retired = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      halted_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      imm_q    <= '0;
      res_q    <= '0;
      alu_op_q <= ALU_ADD;
      taken_q  <= 1'b0;
      dbg_a_q  <= '0;
      dbg_b_q  <= '0;
      dbg_r_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        FETCH: if (imem.ack) ir_q <= imem.rdata;
        // DECODE -> EXEC boundary: operands and immediate captured
        DECODE: begin
          if (!legal) begin
            halted_q <= 1'b1;
          end else begin
            opa_q    <= rs1_val;
            opb_q    <= (opcode == OPCODE_I) ? imm_i : rs2_val;
            imm_q    <= imm_b;
            alu_op_q <= dec_op;
          end
        end
        // EXEC -> WB boundary: result, branch decision and debug taps
        EXEC: begin
          res_q   <= alu_res;
          taken_q <= taken_c;
          dbg_a_q <= opa_q[7:0];
          dbg_b_q <= opb_q[7:0];
          dbg_r_q <= alu_res[7:0];
        end
        WB: begin
          if ((opcode == OPCODE_R || opcode == OPCODE_I) && rd != 5'd0 && int'(rd) < NREGS)
            regs_q[rd] <= res_q;
          pc_q <= pc_d;
        end
        default: ;
      endcase
    end
  end

  assign imem.addr  = imem.req ? pc_q : '0;
  assign dbg_pc     = pc_q;
  assign dbg_src_a  = dbg_a_q;
  assign dbg_src_b  = dbg_b_q;
  assign dbg_result = dbg_r_q;
  assign halted     = halted_q;
endmodule

// File: tb/tb_rv_multicycle_core.sv
module tb_rv_multicycle_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        step_en = 1'b0;
  logic        run = 1'b0;
  logic [31:0] dbg_pc;
  logic [7:0]  dbg_src_a, dbg_src_b, dbg_result;
  logic        retired, halted;

  always #5 clk = ~clk;

  rv_multicycle_core_if #(.XLEN(32)) imem_if ();

  rv_multicycle_core #(.XLEN(32), .MEM_BYTES(64), .RESET_PC(32'h0), .NREGS(32)) dut (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .step_en    (step_en),
    .run        (run),
    .imem       (imem_if),
    .dbg_pc     (dbg_pc),
    .dbg_src_a  (dbg_src_a),
    .dbg_src_b  (dbg_src_b),
    .dbg_result (dbg_result),
    .retired    (retired),
    .halted     (halted)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  // Instruction memory model with programmable ack delay
  logic [31:0] mem [16];
  int          ack_delay = 0;
  int          wait_cnt = 0;

  initial begin
    imem_if.ack   = 1'b0;
    imem_if.rdata = 32'hDEADBEEF;
  end

  always @(negedge clk) begin
    if (imem_if.req && !imem_if.ack) begin
      if (wait_cnt >= ack_delay) begin
        imem_if.ack   = 1'b1;
        imem_if.rdata = mem[imem_if.addr[5:2]];
        wait_cnt      = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      imem_if.ack   = 1'b0;
      imem_if.rdata = 32'hDEADBEEF;
    end
  end

  // Scoreboard: expectation pushed when an instruction is launched
  typedef struct {
    int          idx;
    logic [7:0]  res;
    logic [31:0] pc;
  } exp_t;
  exp_t        sb_q[$];
  logic        pend_pc = 1'b0;
  logic [31:0] pend_exp_pc = '0;
  int          pend_idx = 0;

  always @(negedge clk) begin
    if (rst) begin
      pend_pc = 1'b0;
    end else begin
      if (pend_pc) begin
        chk($sformatf("pc_after#%0d", pend_idx), dbg_pc, pend_exp_pc);
        pend_pc = 1'b0;
      end
      if (retired) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_retire: got retire at pc 0x%08h, required none", dbg_pc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk($sformatf("result#%0d", e.idx), {24'h0, dbg_result}, {24'h0, e.res});
          pend_pc     = 1'b1;
          pend_exp_pc = e.pc;
          pend_idx    = e.idx;
        end
      end
    end
  end

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    logic [12:0] b;
    b = imm[12:0];
    return {b[12], b[10:5], rs2, rs1, f3, b[4:1], b[11], 7'b1100011};
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  res;
    logic [31:0] pc;
  } vec_t;
  vec_t        vecs[24];
  logic [31:0] cur_pc = '0;

  task automatic set_vec(input int i, input logic [31:0] w, input logic [7:0] r, input logic [31:0] p);
    vecs[i].instr = w;
    vecs[i].res   = r;
    vecs[i].pc    = p;
  endtask

  task automatic push_exp(input int idx, input logic [7:0] r, input logic [31:0] p);
    exp_t e;
    e.idx = idx;
    e.res = r;
    e.pc  = p;
    sb_q.push_back(e);
  endtask

  // Place w at cur_pc, pulse step_en, wait for retire; returns latency in cycles.
  task automatic step_instr(input int idx, input logic [31:0] w, input logic [7:0] r,
                            input logic [31:0] p, output int lat);
    mem[cur_pc[5:2]] = w;
    push_exp(idx, r, p);
    step_en = 1'b1;
    @(negedge clk);
    step_en = 1'b0;
    lat = 1;
    while (!retired && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("retire_seen#%0d", idx), {31'h0, retired}, 32'h1);
    cur_pc = p;
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dbg_pc"}, dbg_pc, 32'h0);
    chk({tag, "_dbg_taps"}, {8'h0, dbg_src_a, dbg_src_b, dbg_result}, 32'h0);
    chk({tag, "_flags"}, {29'h0, retired, halted, imem_if.req}, 32'h0);
    chk({tag, "_imem_addr"}, imem_if.addr, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cur_pc = '0;
  endtask

  initial begin
    int lat, n, held, nreq;
    logic seen_req;

    set_vec(0,  enc_i(12'd5, 5'd0, 3'd0, 5'd1),               8'h05, 32'd4);
    set_vec(1,  enc_i(12'd7, 5'd0, 3'd0, 5'd2),               8'h07, 32'd8);
    set_vec(2,  enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3),         8'h0C, 32'd12);
    set_vec(3,  enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4),         8'hFE, 32'd16);
    set_vec(4,  enc_r(7'h00, 5'd1, 5'd4, 3'd2, 5'd5),         8'h01, 32'd20);
    set_vec(5,  enc_r(7'h00, 5'd1, 5'd4, 3'd3, 5'd6),         8'h00, 32'd24);
    set_vec(6,  enc_i(12'hFFF, 5'd1, 3'd4, 5'd7),             8'hFA, 32'd28);
    set_vec(7,  enc_i(12'h401, 5'd4, 3'd5, 5'd8),             8'hFF, 32'd32);
    set_vec(8,  enc_i(12'd28, 5'd4, 3'd5, 5'd9),              8'h0F, 32'd36);
    set_vec(9,  enc_i(12'd4, 5'd1, 3'd1, 5'd10),              8'h50, 32'd40);
    set_vec(10, enc_r(7'h00, 5'd2, 5'd3, 3'd7, 5'd11),        8'h04, 32'd44);
    set_vec(11, enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd12),        8'h07, 32'd48);
    set_vec(12, enc_i(12'd9, 5'd0, 3'd0, 5'd0),               8'h09, 32'd52);
    set_vec(13, enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd13),        8'h00, 32'd56);
    set_vec(14, enc_i(12'hFFF, 5'd4, 3'd2, 5'd14),            8'h01, 32'd60);
    set_vec(15, enc_i(12'd1, 5'd0, 3'd0, 5'd1),               8'h01, 32'd0);
    set_vec(16, enc_b(-8, 5'd1, 5'd0, 3'd1),                  8'hFF, 32'd56);
    set_vec(17, enc_r(7'h20, 5'd1, 5'd0, 3'd0, 5'd4),         8'hFF, 32'd60);
    set_vec(18, enc_r(7'h00, 5'd0, 5'd4, 3'd2, 5'd5),         8'h01, 32'd0);
    set_vec(19, enc_r(7'h00, 5'd0, 5'd4, 3'd3, 5'd6),         8'h00, 32'd4);
    set_vec(20, enc_i(12'd24, 5'd4, 3'd5, 5'd7),              8'hFF, 32'd8);
    set_vec(21, enc_b(8, 5'd2, 5'd1, 3'd0),                   8'hFA, 32'd12);
    set_vec(22, enc_b(-12, 5'd0, 5'd4, 3'd5),                 8'hFF, 32'd16);
    set_vec(23, enc_b(-16, 5'd0, 5'd4, 3'd4),                 8'hFF, 32'd0);
    for (int i = 0; i < 16; i++) mem[i] = 32'h0000007F;

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Free-running three-instruction program
    mem[0] = vecs[0].instr;
    mem[1] = vecs[1].instr;
    mem[2] = vecs[2].instr;
    push_exp(100, 8'h05, 32'd4);
    push_exp(101, 8'h07, 32'd8);
    push_exp(102, 8'h0C, 32'd12);
    run = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < 3; c++) begin
      @(negedge clk);
      if (retired) n++;
    end
    run = 1'b0;
    chk("run_retire_count", n, 32'd3);
    repeat (3) @(negedge clk);
    chk("run_stopped_req", {31'h0, imem_if.req}, 32'h0);

    do_reset();
    chk_reset_outputs("reset2");

    for (int i = 0; i < 24; i++) begin
      step_instr(i, vecs[i].instr, vecs[i].res, vecs[i].pc, lat);
      if (i == 0) chk("step_latency", lat, 32'd4);
    end

    // Second step_en during DECODE must be ignored
    mem[cur_pc[5:2]] = enc_i(12'h033, 5'd0, 3'd0, 5'd15);
    push_exp(200, 8'h33, 32'd4);
    step_en = 1'b1;
    @(negedge clk);
    step_en = 1'b0;
    @(negedge clk);
    step_en = 1'b1;
    @(negedge clk);
    step_en = 1'b0;
    lat = 3;
    while (!retired && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("step2_latency", lat, 32'd4);
    cur_pc = 32'd4;
    seen_req = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (imem_if.req) seen_req = 1'b1;
    end
    chk("step_ignored_no_fetch", {31'h0, seen_req}, 32'h0);

    // Delayed ack: request and address must hold
    ack_delay = 5;
    mem[cur_pc[5:2]] = enc_i(12'd2, 5'd1, 3'd0, 5'd16);
    push_exp(300, 8'h03, 32'd8);
    step_en = 1'b1;
    @(negedge clk);
    step_en = 1'b0;
    lat = 1;
    held = 0;
    repeat (5) begin
      if (imem_if.req && imem_if.addr == cur_pc && dbg_pc == cur_pc) held++;
      @(negedge clk);
      lat++;
    end
    chk("fetch_held_cycles", held, 32'd5);
    while (!retired && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("delayed_latency", lat, 32'd9);
    cur_pc = 32'd8;
    @(negedge clk);
    ack_delay = 0;

    // Illegal opcode halts and blocks further starts
    mem[cur_pc[5:2]] = 32'h0000007F;
    run = 1'b1;
    nreq = 0;
    repeat (20) begin
      @(negedge clk);
      if (imem_if.req) nreq++;
    end
    chk("halted_set", {31'h0, halted}, 32'h1);
    chk("halt_fetch_cycles", nreq, 32'd1);
    chk("halt_pc_unchanged", dbg_pc, cur_pc);
    run = 1'b0;

    do_reset();
    chk_reset_outputs("reset_after_halt");

    step_instr(400, enc_i(12'd5, 5'd0, 3'd0, 5'd1), 8'h05, 32'd4, lat);

    // Reset during EXEC aborts without retire or write
    mem[cur_pc[5:2]] = enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd3);
    step_en = 1'b1;
    @(negedge clk);
    step_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cur_pc = '0;
    chk_reset_outputs("abort");
    step_instr(401, enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd3), 8'h00, 32'd4, lat);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end
endmodule
